// File: rtl/wt_dcache_port_arb.sv
// ---------------------------------------------------------------------------
// wt_dcache_port_arb : round-robin arbiter sharing one wt_dcache read port,
//   locking the port to its owner from data_gnt until data_rvalid.
//   Optional per-requester stall counters: WT_DCACHE_PORT_ARB_PERF_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wt_dcache_port_arb_pkg;
  typedef struct packed {
    logic [11:0] address_index;
    logic [43:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module wt_dcache_port_arb
  import wt_dcache_port_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned RrW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  dcache_req_i_t  req_ports_i [NumReq],
  output dcache_req_o_t  req_ports_o [NumReq],
  output dcache_req_i_t  dcache_req_o,
  input  dcache_req_o_t  dcache_rsp_i,
  output logic           busy_o,
  output logic [RrW-1:0] owner_o,
  output logic [31:0]    stall_cnt_o [NumReq]
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e         r_state;
  logic [RrW-1:0] r_rr;
  logic [RrW-1:0] r_owner;

  logic           w_found_hi;
  logic           w_found_any;
  logic [RrW-1:0] w_win_hi;
  logic [RrW-1:0] w_win_any;
  logic [RrW-1:0] w_winner;
  logic [RrW-1:0] w_rr_next;
  logic           w_has_winner;
  logic           w_grant;

  // Descending scan leaves the lowest matching index: lowest at/above r_rr
  // wins, otherwise the lowest overall (the wrap-around case).
  always_comb begin
    w_found_hi  = 1'b0;
    w_found_any = 1'b0;
    w_win_hi    = '0;
    w_win_any   = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      if (req_ports_i[k].data_req) begin
        w_found_any = 1'b1;
        w_win_any   = RrW'(k);
        if (RrW'(k) >= r_rr) begin
          w_found_hi = 1'b1;
          w_win_hi   = RrW'(k);
        end
      end
    end
  end

  assign w_winner     = w_found_hi ? w_win_hi : w_win_any;
  assign w_has_winner = rst_ni && (r_state == ST_IDLE) && !flush_i && w_found_any;
  assign w_grant      = w_has_winner && dcache_rsp_i.data_gnt;
  assign w_rr_next    = (32'(w_winner) == NumReq - 1) ? '0 : w_winner + 1'b1;

  always_comb begin
    dcache_req_o = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      req_ports_o[k] = '0;
    end
    if (w_has_winner) begin
      dcache_req_o = req_ports_i[w_winner];
      req_ports_o[w_winner].data_gnt = dcache_rsp_i.data_gnt;
    end else if (rst_ni && (r_state == ST_BUSY)) begin
      // Owner keeps tag/kill phase; a stray gnt here is deliberately dropped.
      dcache_req_o          = req_ports_i[r_owner];
      dcache_req_o.data_req = 1'b0;
      req_ports_o[r_owner].data_rvalid = dcache_rsp_i.data_rvalid;
      req_ports_o[r_owner].data_rdata  = dcache_rsp_i.data_rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_rr    <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_BUSY;
            r_owner <= w_winner;
            r_rr    <= w_rr_next;
          end
        end
        ST_BUSY: begin
          if (dcache_rsp_i.data_rvalid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state == ST_BUSY);
  assign owner_o = r_owner;

`ifdef WT_DCACHE_PORT_ARB_PERF_EN
  for (genvar k = 0; k < NumReq; k++) begin : g_perf
    logic [31:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (req_ports_i[k].data_req && !req_ports_o[k].data_gnt &&
                   (r_cnt != 32'hFFFF_FFFF)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign stall_cnt_o[k] = r_cnt;
  end
`else
  for (genvar k = 0; k < NumReq; k++) begin : g_no_perf
    assign stall_cnt_o[k] = '0;
  end
`endif

endmodule

`default_nettype wire

// File: doc/wt_dcache_port_arb.md
Name: wt_dcache_port_arb

Overview:
- Arbiter that shares one write-through dcache read port (a `dcache_req_i_t`/`dcache_req_o_t` pair) among NumReq requesters, e.g. PTW plus an IOMMU/accelerator walker.
- Sits between the requesters and one read port of `wt_dcache`.
- Round-robin grant with ownership lock: the owner holds the port from `data_gnt` until `data_rvalid`, so the index/tag/response phases of one transaction never interleave with another requester's.

Parameters:
- NumReq, 2, number of requesters sharing the port; legal range 1..8.
- RrW, `(NumReq>1)?$clog2(NumReq):1`, width of the round-robin pointer and owner index (derived; not to be overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  blocks new grants while high; transactions already in flight complete.
- req_ports_i  in  NumReq x dcache_req_i_t  requests from requesters.
- req_ports_o  out  NumReq x dcache_req_o_t  responses to requesters.
- dcache_req_o  out  dcache_req_i_t  request into the dcache read port.
- dcache_rsp_i  in  dcache_req_o_t  response from the dcache read port.
- busy_o  out  1  high while state is BUSY.
- owner_o  out  RrW  index of the current owner; valid only when busy_o=1.
- stall_cnt_o  out  NumReq x 32  per-requester stall counters (see Optional Feature).

Behaviour:
- Reset values:
  - state=IDLE, rr_q=0, owner_q=0.
  - busy_o=0, owner_o=0.
  - All `req_ports_o` fields 0.
  - `dcache_req_o` all fields 0.
  - stall_cnt_o all 0.
- State IDLE:
  - Winner = first k with `req_ports_i[k].data_req=1`, searching from rr_q upward with wrap at NumReq-1 -> 0.
  - flush_i=1 or no requester -> no winner; `dcache_req_o` = 0.
  - With a winner, `dcache_req_o` = `req_ports_i[winner]`, combinationally in the same cycle.
  - `dcache_rsp_i.data_gnt` routed only to `req_ports_o[winner].data_gnt`.
  - On `data_gnt=1`: owner_q <= winner, rr_q <= (winner+1) mod NumReq, state <= BUSY.
  - Winner may change cycle to cycle until a grant occurs; no lock before gnt.
- State BUSY:
  - `dcache_req_o` = `req_ports_i[owner_q]` with `data_req` forced to 0.
  - address_tag, tag_valid and kill_req pass through unmodified.
  - `dcache_rsp_i.data_rvalid`/`data_rdata` routed only to owner_q.
  - On `data_rvalid=1`: state <= IDLE. The first new arbitration is the following cycle; there is no same-cycle re-grant.
  - Killed transactions still terminate with `data_rvalid`, per the dcache port contract; the arbiter does not exit BUSY on kill_req alone.
  - flush_i has no effect in BUSY.
- Non-owners / non-winners:
  - data_gnt=0, data_rvalid=0, data_rdata=0 in every cycle.
- Boundaries:
  - `data_gnt` asserted by the dcache in BUSY (protocol violation): ignored, and not routed to any requester.
  - `data_rvalid` in IDLE: dropped.
  - NumReq=1: rr_q constant 0; behaves as a lock-tracking pass-through.
  - Reset mid-BUSY: immediate return to IDLE; the outstanding response is lost.
  - Requester deasserting data_req before gnt: loses the slot; rr_q unchanged.
- Latency: zero added cycles on request, grant and response paths (purely combinational muxing); one bubble cycle between back-to-back transactions.

Optional Feature:
- Macro: WT_DCACHE_PORT_ARB_PERF_EN.
- Defined: stall_cnt_o[k] increments by 1 each cycle `req_ports_i[k].data_req=1` and `req_ports_o[k].data_gnt=0`.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 only by rst_ni.
- Undefined: stall_cnt_o tied to 0; no counter flops.

Test Plan:
- Single requester: NumReq=2, req0 raises data_req, dcache gnt in same cycle -> req_ports_o[0].data_gnt=1; busy_o=1 next cycle; owner_o=0; rvalid 3 cycles later routed to req0 only with rdata=64'hDEAD_BEEF; busy_o=0 next cycle.
- Fairness: both requesters hold data_req continuously, dcache grants at once and rvalid after 1 cycle -> grant order 0,1,0,1; each transaction takes 3 cycles including the bubble; rr_q=0 after the 4th grant (wrap).
- Lock: req1 raises data_req while req0 owns the port -> dcache_req_o.data_req=0 until req0's rvalid; req1 granted the cycle after the bubble, never during BUSY.
- Flush: flush_i=1 while BUSY -> owner's rvalid still delivered, then no grants while flush_i=1 despite pending req1; grant in the first cycle after flush_i falls.
- Kill: owner asserts kill_req in BUSY -> kill_req seen on dcache_req_o; arbiter stays BUSY until dcache_rvalid, then IDLE.
- Perf (macro defined): req1 stalled 5 cycles behind req0 -> stall_cnt_o[1]=5, stall_cnt_o[0]=0; macro undefined -> both counters 0.
